// File: rtl/painterengine_gpu_dma_writer.sv
// painterengine_gpu_dma_writer
//   AXI4 write-master DMA. Streams 32-bit words from one of four GPU pipeline
//   sources into memory as INCR bursts of at most 256 beats that never cross a
//   1 KB boundary. Runs once per reset to DONE or ERROR, then holds there.
//
// Ports
//   i_wire_clock / i_wire_resetn    clock, synchronous active-low reset
//   i_wire_router                   one-hot source select (slot 0..3)
//   i_wire_address / i_wire_length  per-slot byte address / word count (32b each)
//   i_wire_data / i_wire_data_valid per-source data lanes and valids
//   o_wire_data_next                per-source pop strobe (word consumed)
//   o_wire_done / o_wire_error      terminal status, o_wire_error_type code:
//                                   0 ok, 1 router, 2 address/length, 3 AW timeout,
//                                   4 W timeout, 5 B timeout, 6 slave error
//   o_wire_M_AXI_AW*/W*/B*          AXI4 write address, data and response channels
module painterengine_gpu_dma_writer #(
  parameter int unsigned TIMEOUT_BIT = 18
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  output logic         o_wire_done,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_data,
  input  logic [3:0]   i_wire_data_valid,
  output logic [3:0]   o_wire_data_next,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_AWID,
  output logic [31:0]  o_wire_M_AXI_AWADDR,
  output logic [7:0]   o_wire_M_AXI_AWLEN,
  output logic [2:0]   o_wire_M_AXI_AWSIZE,
  output logic [1:0]   o_wire_M_AXI_AWBURST,
  output logic         o_wire_M_AXI_AWLOCK,
  output logic [3:0]   o_wire_M_AXI_AWCACHE,
  output logic [2:0]   o_wire_M_AXI_AWPROT,
  output logic [3:0]   o_wire_M_AXI_AWQOS,
  output logic         o_wire_M_AXI_AWVALID,
  input  logic         i_wire_M_AXI_AWREADY,
  output logic [31:0]  o_wire_M_AXI_WDATA,
  output logic [3:0]   o_wire_M_AXI_WSTRB,
  output logic         o_wire_M_AXI_WLAST,
  output logic         o_wire_M_AXI_WVALID,
  input  logic         i_wire_M_AXI_WREADY,
  input  logic         i_wire_M_AXI_BID,
  input  logic [1:0]   i_wire_M_AXI_BRESP,
  input  logic         i_wire_M_AXI_BVALID,
  output logic         o_wire_M_AXI_BREADY
);

  typedef enum logic [2:0] {
    StRouting,
    StParamCheck,
    StCalc,
    StAw,
    StWdata,
    StBresp,
    StDone,
    StError
  } state_e;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrRouter  = 3'd1;
  localparam logic [2:0] ErrAddress = 3'd2;
  localparam logic [2:0] ErrAwTmo   = 3'd3;
  localparam logic [2:0] ErrWTmo    = 3'd4;
  localparam logic [2:0] ErrBTmo    = 3'd5;
  localparam logic [2:0] ErrSlave   = 3'd6;

  state_e               r_state;
  state_e               w_state_next;
  logic [2:0]           r_error_type;
  logic [2:0]           w_error_type_next;

  logic [1:0]           r_idx;
  logic [31:0]          r_address;
  logic [31:0]          r_length;
  logic [31:0]          r_offset;
  logic [8:0]           r_burst_len;
  logic [7:0]           r_beat;
  logic [TIMEOUT_BIT:0] r_timeout;

  logic                 w_router_ok;
  logic [1:0]           w_router_idx;
  logic [31:0]          w_remaining;
  logic [7:0]           w_word_in_kb;
  logic [8:0]           w_room;
  logic [8:0]           w_burst_len;
  logic [31:0]          w_offset_sum;
  logic                 w_timeout;
  logic                 w_last_beat;
  logic                 w_sel_valid;
  logic [31:0]          w_sel_data;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_b_hs;
  logic                 w_in_wait;
  logic                 w_unused_bid;

  // BID is not checked: only one burst is ever outstanding.
  assign w_unused_bid = i_wire_M_AXI_BID;

  // Router decode; anything other than a single set bit is rejected.
  always_comb begin
    w_router_ok  = 1'b1;
    w_router_idx = 2'd0;
    case (i_wire_router)
      4'b0001: w_router_idx = 2'd0;
      4'b0010: w_router_idx = 2'd1;
      4'b0100: w_router_idx = 2'd2;
      4'b1000: w_router_idx = 2'd3;
      default: w_router_ok  = 1'b0;
    endcase
  end

  // Burst sizing: words left before the next 1 KB boundary (1..256), capped by
  // the words still to transfer.
  assign w_remaining  = r_length - r_offset;
  assign w_word_in_kb = r_address[9:2] + r_offset[7:0];
  assign w_room       = 9'd256 - {1'b0, w_word_in_kb};
  assign w_burst_len  = (w_remaining < {23'd0, w_room}) ? w_remaining[8:0] : w_room;
  assign w_offset_sum = r_offset + {23'd0, r_burst_len};

  assign w_timeout    = r_timeout[TIMEOUT_BIT];
  assign w_last_beat  = ({1'b0, r_beat} == (r_burst_len - 9'd1));
  assign w_sel_valid  = i_wire_data_valid[r_idx];
  assign w_sel_data   = i_wire_data[{r_idx, 5'd0} +: 32];
  assign w_in_wait    = (r_state == StAw) || (r_state == StWdata) || (r_state == StBresp);

  assign w_aw_hs = o_wire_M_AXI_AWVALID & i_wire_M_AXI_AWREADY;
  assign w_w_hs  = o_wire_M_AXI_WVALID & i_wire_M_AXI_WREADY;
  assign w_b_hs  = o_wire_M_AXI_BREADY & i_wire_M_AXI_BVALID;

  // State register.
  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      r_state      <= StRouting;
      r_error_type <= ErrNone;
    end else begin
      r_state      <= w_state_next;
      r_error_type <= w_error_type_next;
    end
  end

  // Next-state logic. The timeout has priority over any handshake in the
  // same cycle.
  always_comb begin
    w_state_next      = r_state;
    w_error_type_next = r_error_type;
    case (r_state)
      StRouting: begin
        if (w_router_ok) begin
          w_state_next = StParamCheck;
        end else begin
          w_state_next      = StError;
          w_error_type_next = ErrRouter;
        end
      end
      StParamCheck: begin
        if ((r_address[1:0] != 2'b00) || (r_length == 32'd0)) begin
          w_state_next      = StError;
          w_error_type_next = ErrAddress;
        end else begin
          w_state_next = StCalc;
        end
      end
      StCalc: w_state_next = StAw;
      StAw: begin
        if (w_timeout) begin
          w_state_next      = StError;
          w_error_type_next = ErrAwTmo;
        end else if (w_aw_hs) begin
          w_state_next = StWdata;
        end
      end
      StWdata: begin
        if (w_timeout) begin
          w_state_next      = StError;
          w_error_type_next = ErrWTmo;
        end else if (w_w_hs && w_last_beat) begin
          w_state_next = StBresp;
        end
      end
      StBresp: begin
        if (w_timeout) begin
          w_state_next      = StError;
          w_error_type_next = ErrBTmo;
        end else if (w_b_hs) begin
          if (i_wire_M_AXI_BRESP != 2'b00) begin
            w_state_next      = StError;
            w_error_type_next = ErrSlave;
          end else if (w_offset_sum >= r_length) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StCalc;
          end
        end
      end
      StDone:  w_state_next = StDone;
      StError: w_state_next = StError;
      default: w_state_next = StError;
    endcase
  end

  // Outputs, decoded from the current state.
  always_comb begin
    o_wire_done          = (r_state == StDone);
    o_wire_error         = (r_state == StError);
    o_wire_error_type    = r_error_type;

    o_wire_M_AXI_AWID    = 1'b0;
    o_wire_M_AXI_AWADDR  = r_address + {r_offset[29:0], 2'b00};
    o_wire_M_AXI_AWLEN   = r_burst_len[7:0] - 8'd1;
    o_wire_M_AXI_AWSIZE  = 3'b010;
    o_wire_M_AXI_AWBURST = 2'b01;
    o_wire_M_AXI_AWLOCK  = 1'b0;
    o_wire_M_AXI_AWCACHE = 4'b0010;
    o_wire_M_AXI_AWPROT  = 3'b000;
    o_wire_M_AXI_AWQOS   = 4'b0000;
    o_wire_M_AXI_AWVALID = (r_state == StAw);

    o_wire_M_AXI_WSTRB   = 4'hF;
    o_wire_M_AXI_WVALID  = (r_state == StWdata) && w_sel_valid;
    o_wire_M_AXI_WDATA   = (r_state == StWdata) ? w_sel_data : 32'd0;
    o_wire_M_AXI_WLAST   = (r_state == StWdata) && w_last_beat;

    o_wire_M_AXI_BREADY  = (r_state == StBresp);

    o_wire_data_next     = 4'b0000;
    if (w_w_hs) begin
      o_wire_data_next[r_idx] = 1'b1;
    end
  end

  // Transfer bookkeeping and the stall watchdog.
  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      r_idx       <= 2'd0;
      r_address   <= 32'd0;
      r_length    <= 32'd0;
      r_offset    <= 32'd0;
      r_burst_len <= 9'd0;
      r_beat      <= 8'd0;
      r_timeout   <= '0;
    end else begin
      case (r_state)
        StRouting: begin
          if (w_router_ok) begin
            r_idx     <= w_router_idx;
            r_address <= i_wire_address[{w_router_idx, 5'd0} +: 32];
            r_length  <= i_wire_length[{w_router_idx, 5'd0} +: 32];
          end
        end
        StParamCheck: begin
          r_offset <= 32'd0;
          r_beat   <= 8'd0;
        end
        StCalc: r_burst_len <= w_burst_len;
        StAw: begin
          if (w_aw_hs) begin
            r_beat <= 8'd0;
          end
        end
        StWdata: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 8'd1;
          end
        end
        StBresp: begin
          if (w_b_hs && (i_wire_M_AXI_BRESP == 2'b00)) begin
            r_offset <= w_offset_sum;
          end
        end
        default: ;
      endcase

      // Counts idle cycles while waiting on the bus or an empty source.
      if ((w_state_next != r_state) || w_aw_hs || w_w_hs || w_b_hs) begin
        r_timeout <= '0;
      end else if (w_in_wait) begin
        r_timeout <= r_timeout + 1'b1;
      end else begin
        r_timeout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Self-checking bench for painterengine_gpu_dma_writer. A transaction-level model
// (burst plan from address/length arithmetic, per-source word sequences, and a
// single-outstanding-burst bus tracker) is compared against the DUT every cycle.
module tb_painterengine_gpu_dma_writer;

  localparam int unsigned TbTimeoutBit = 6;

  logic         clk = 1'b0;
  logic         resetn;
  logic         done;
  logic [127:0] address;
  logic [127:0] length;
  logic [3:0]   router;
  logic [127:0] data;
  logic [3:0]   data_valid;
  logic [3:0]   data_next;
  logic         error;
  logic [2:0]   err_type;
  logic         awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic [3:0]   awqos;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_writer #(
    .TIMEOUT_BIT(TbTimeoutBit)
  ) u_dut (
    .i_wire_clock         (clk),
    .i_wire_resetn        (resetn),
    .o_wire_done          (done),
    .i_wire_address       (address),
    .i_wire_length        (length),
    .i_wire_router        (router),
    .i_wire_data          (data),
    .i_wire_data_valid    (data_valid),
    .o_wire_data_next     (data_next),
    .o_wire_error         (error),
    .o_wire_error_type    (err_type),
    .o_wire_M_AXI_AWID    (awid),
    .o_wire_M_AXI_AWADDR  (awaddr),
    .o_wire_M_AXI_AWLEN   (awlen),
    .o_wire_M_AXI_AWSIZE  (awsize),
    .o_wire_M_AXI_AWBURST (awburst),
    .o_wire_M_AXI_AWLOCK  (awlock),
    .o_wire_M_AXI_AWCACHE (awcache),
    .o_wire_M_AXI_AWPROT  (awprot),
    .o_wire_M_AXI_AWQOS   (awqos),
    .o_wire_M_AXI_AWVALID (awvalid),
    .i_wire_M_AXI_AWREADY (awready),
    .o_wire_M_AXI_WDATA   (wdata),
    .o_wire_M_AXI_WSTRB   (wstrb),
    .o_wire_M_AXI_WLAST   (wlast),
    .o_wire_M_AXI_WVALID  (wvalid),
    .i_wire_M_AXI_WREADY  (wready),
    .i_wire_M_AXI_BID     (bid),
    .i_wire_M_AXI_BRESP   (bresp),
    .i_wire_M_AXI_BVALID  (bvalid),
    .o_wire_M_AXI_BREADY  (bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scenario controls
  bit          want_reset = 1'b1;
  int          hold_mode  = 0;   // 0 none, 1 AWREADY low, 2 source valid low, 3 BVALID low
  int          err_burst  = -1;  // burst index answered with SLVERR
  bit          wr_always  = 1'b0;
  int unsigned sel        = 0;
  int unsigned exp_addr[$];
  int unsigned exp_len[$];
  int unsigned pop_cnt[4];
  logic [3:0]  src_valid  = 4'b0000;

  // Bus tracker
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, aw_seen = 0;
  int unsigned beat = 0;
  bit          aw_open = 1'b0, b_pending = 1'b0, prev_rst_low = 1'b0;
  logic [31:0] log_awaddr[8];
  logic [7:0]  log_awlen[8];
  logic [31:0] first_wdata = '0, last_wdata = '0;

  function automatic logic [31:0] word(int unsigned k, int unsigned i);
    return (k << 24) | (32'hA0 + i);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Burst plan: cut at every 256-word (1 KB) boundary.
  function automatic void plan(logic [31:0] addr, int unsigned len);
    int unsigned off = 0;
    exp_addr.delete();
    exp_len.delete();
    while (off < len) begin
      int unsigned a    = addr + off * 4;
      int unsigned room = 256 - ((a >> 2) % 256);
      int unsigned n    = ((len - off) < room) ? (len - off) : room;
      exp_addr.push_back(a);
      exp_len.push_back(n);
      off += n;
    end
  endfunction

  task automatic drive();
    resetn  = !want_reset;
    awready = (hold_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    wready  = wr_always ? 1'b1 : 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) begin
      if (!src_valid[k]) begin
        src_valid[k] = (hold_mode == 2 && k == int'(sel)) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      data[k*32 +: 32] = word(k, pop_cnt[k]);
    end
    data_valid = src_valid;
    if (want_reset || !b_pending || hold_mode == 3) begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end else if (!bvalid) begin
      bvalid = 1'($urandom_range(0, 1));
      bresp  = (err_burst == b_cnt) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic monitor();
    bit         in_w, in_b;
    logic [3:0] exp_next;
    if (prev_rst_low) begin
      check("reset_status", {done, error, err_type, awvalid, wvalid, bready}, 8'd0);
      check("reset_data_next", data_next, 4'd0);
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_seen = 0; beat = 0;
      aw_open = 1'b0; b_pending = 1'b0;
    end else if (done || error) begin
      check("terminal_quiet", {awvalid, wvalid, bready, data_next}, 7'd0);
    end else begin
      in_w = aw_open;
      in_b = b_pending;
      if (awvalid) begin
        aw_seen++;
        check("aw_single_outstanding", {aw_open, b_pending}, 2'b00);
        check("aw_constants", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
              {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
        if (awready) begin
          if (aw_cnt < exp_addr.size()) begin
            check("awaddr", awaddr, exp_addr[aw_cnt]);
            check("awlen", awlen, exp_len[aw_cnt] - 1);
          end else begin
            check("aw_extra_burst", aw_cnt, exp_addr.size());
          end
          if (aw_cnt < 8) begin
            log_awaddr[aw_cnt] = awaddr;
            log_awlen[aw_cnt]  = awlen;
          end
          aw_cnt++;
          aw_open = 1'b1;
          beat    = 0;
        end
      end
      if (in_w) begin
        check("wvalid_follows_source", wvalid, data_valid[sel]);
        if (wvalid) begin
          check("wdata", wdata, word(sel, w_cnt));
          check("wlast", wlast, beat == exp_len[aw_cnt-1] - 1);
          check("wstrb", wstrb, 4'hF);
        end
      end else begin
        check("wvalid_idle", wvalid, 1'b0);
      end
      exp_next = (wvalid && wready) ? (4'b0001 << sel) : 4'b0000;
      check("data_next", data_next, exp_next);
      if (in_w && wvalid && wready) begin
        if (w_cnt == 0) first_wdata = wdata;
        w_cnt++;
        pop_cnt[sel]++;
        src_valid[sel] = 1'b0;
        if (beat == exp_len[aw_cnt-1] - 1) begin
          aw_open    = 1'b0;
          b_pending  = 1'b1;
          last_wdata = wdata;
        end else begin
          beat++;
        end
      end
      if (in_b) begin
        check("bready", bready, 1'b1);
        if (bvalid && bready) begin
          b_cnt++;
          b_pending = 1'b0;
        end
      end else begin
        check("bready_idle", bready, 1'b0);
      end
    end
    prev_rst_low = !resetn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic start_case(logic [3:0] rt, logic [31:0] addr, int unsigned len,
                            int hold, int errb, bit wr_all);
    want_reset = 1'b1;
    tick();
    hold_mode = hold;
    err_burst = errb;
    wr_always = wr_all;
    router    = rt;
    sel       = 0;
    for (int k = 0; k < 4; k++) begin
      if (rt[k]) sel = k;
      address[k*32 +: 32] = $urandom;
      length[k*32 +: 32]  = $urandom;
      pop_cnt[k] = 0;
    end
    address[sel*32 +: 32] = addr;
    length[sel*32 +: 32]  = len;
    src_valid = 4'b0000;
    plan(addr, len);
    tick();
    tick();
    want_reset = 1'b0;
  endtask

  task automatic finish_case(logic [3:0] rt, logic [31:0] addr, int unsigned len);
    int exp_type, exp_aws, exp_words, cyc;
    exp_type = 0; exp_aws = 0; exp_words = 0;
    if (!(rt inside {4'b0001, 4'b0010, 4'b0100, 4'b1000})) begin
      exp_type = 1;
    end else if (addr[1:0] != 2'b00 || len == 0) begin
      exp_type = 2;
    end else if (hold_mode == 1) begin
      exp_type = 3;
    end else if (hold_mode == 2) begin
      exp_type = 4; exp_aws = 1;
    end else if (hold_mode == 3) begin
      exp_type = 5; exp_aws = 1; exp_words = exp_len[0];
    end else if (err_burst >= 0 && err_burst < exp_addr.size()) begin
      exp_type = 6; exp_aws = err_burst + 1;
      for (int i = 0; i <= err_burst; i++) exp_words += exp_len[i];
    end else begin
      exp_aws = exp_addr.size(); exp_words = len;
    end
    cyc = 0;
    while (!(done || error) && cyc < 8000) begin
      tick();
      cyc++;
    end
    check("finished_in_time", done | error, 1'b1);
    check("done", done, exp_type == 0);
    check("error", error, exp_type != 0);
    check("error_type", err_type, exp_type);
    check("aw_count", aw_cnt, exp_aws);
    check("w_count", w_cnt, exp_words);
    check("src_pops", pop_cnt[sel], exp_words);
    if (exp_type == 1 || exp_type == 2) check("no_awvalid", aw_seen, 0);
    if (exp_type == 3) check("aw_timeout_span", aw_seen >= 64, 1'b1);
    repeat (4) tick();
    check("sticky_status", {done, error, err_type},
          {1'(exp_type == 0), 1'(exp_type != 0), 3'(exp_type)});
  endtask

  task automatic run_case(logic [3:0] rt, logic [31:0] addr, int unsigned len,
                          int hold, int errb, bit wr_all);
    start_case(rt, addr, len, hold, errb, wr_all);
    finish_case(rt, addr, len);
  endtask

  initial begin
    resetn = 1'b0; router = 4'd0; address = '0; length = '0; data = '0;
    data_valid = 4'd0; awready = 1'b0; wready = 1'b0; bid = 1'b0;
    bresp = 2'b00; bvalid = 1'b0;
    for (int k = 0; k < 4; k++) pop_cnt[k] = 0;

    // Single short burst, WREADY always high.
    run_case(4'b0001, 32'h1000, 4, 0, -1, 1'b1);
    check("c1_awaddr", log_awaddr[0], 32'h1000);
    check("c1_awlen", log_awlen[0], 8'd3);
    check("c1_first_word", first_wdata, 32'hA0);
    check("c1_last_word", last_wdata, 32'hA3);
    check("c1_pops", pop_cnt[0], 4);

    // Split at the 1 KB boundary.
    run_case(4'b0100, 32'h3F8, 6, 0, -1, 1'b0);
    check("c2_aw0", log_awaddr[0], 32'h3F8);
    check("c2_len0", log_awlen[0], 8'd1);
    check("c2_aw1", log_awaddr[1], 32'h400);
    check("c2_len1", log_awlen[1], 8'd3);

    // Full 256-beat burst followed by the remainder.
    run_case(4'b1000, 32'h0, 300, 0, -1, 1'b0);
    check("c3_len0", log_awlen[0], 8'd255);
    check("c3_aw1", log_awaddr[1], 32'h400);
    check("c3_len1", log_awlen[1], 8'd43);
    check("c3_last_word", last_wdata, 32'h030001CB);

    // Parameter errors.
    run_case(4'b0011, 32'h1000, 4, 0, -1, 1'b0);
    run_case(4'b0010, 32'h1002, 4, 0, -1, 1'b0);
    run_case(4'b0010, 32'h1000, 0, 0, -1, 1'b0);

    // Slave error on the first burst.
    run_case(4'b0001, 32'h0, 300, 0, 0, 1'b0);

    // Timeouts on each channel.
    run_case(4'b0001, 32'h2000, 8, 1, -1, 1'b0);
    run_case(4'b0010, 32'h2000, 8, 2, -1, 1'b0);
    run_case(4'b0100, 32'h2000, 8, 3, -1, 1'b0);

    // Reset in the middle of a burst.
    begin
      int cyc = 0;
      start_case(4'b1000, 32'h0, 300, 0, -1, 1'b0);
      while (w_cnt < 20 && cyc < 2000) begin
        tick();
        cyc++;
      end
      check("mid_reset_progress", w_cnt >= 20, 1'b1);
    end

    // Randomised transfers.
    for (int n = 0; n < 6; n++) begin
      int unsigned k   = $urandom_range(0, 3);
      logic [31:0] a   = $urandom & 32'h0000_3FFC;
      int unsigned len = $urandom_range(1, 600);
      run_case(4'(1 << k), a, len, 0, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_dma_writer.md
Name: painterengine_gpu_dma_writer

Overview:
- AXI4 full write-master DMA: streams 32-bit words from one of four GPU pipeline sources into memory at a routed address/length.
- Counterpart of the GPU DMA reader; the reader feeds the pipeline, this block writes results (framebuffer, texture out) back.
- Splits transfers into INCR bursts of ≤256 beats that never cross a 1 KB (256-word) boundary.
- One-shot per reset: runs to done or error, then holds.

Parameters:
TIMEOUT_BIT, 18, index of timeout counter bit that triggers a timeout error (counter width TIMEOUT_BIT+1)

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  synchronous active-low reset
o_wire_done  out  1  high while in DONE
i_wire_address  in  128  four 32-bit byte addresses, slot k at [k*32+:32]
i_wire_length  in  128  four 32-bit word counts
i_wire_router  in  4  one-hot source select (1,2,4,8)
i_wire_data  in  128  four 32-bit source data lanes
i_wire_data_valid  in  4  per-source data valid
o_wire_data_next  out  4  per-source pop strobe (word consumed)
o_wire_error  out  1  high while in ERROR
o_wire_error_type  out  3  0 ok, 1 router, 2 address, 3 AW timeout, 4 W timeout, 5 B timeout, 6 slave error
o_wire_M_AXI_AWID/AWADDR[31:0]/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWLOCK/AWCACHE[3:0]/AWPROT[2:0]/AWQOS[3:0]/AWVALID  out; i_wire_M_AXI_AWREADY  in
o_wire_M_AXI_WDATA[31:0]/WSTRB[3:0]/WLAST/WVALID  out; i_wire_M_AXI_WREADY  in
i_wire_M_AXI_BID, i_wire_M_AXI_BRESP[1:0], i_wire_M_AXI_BVALID  in; o_wire_M_AXI_BREADY  out

Behaviour:
- Single clock i_wire_clock; reset synchronous, active-low on i_wire_resetn. Reset: state ROUTING, all counters 0, AWVALID=0, WVALID=0, BREADY=0, error_type=0, done=0, error=0, data_next=0.
- Constants: AWID=0, AWSIZE=3'b010, AWBURST=INCR, AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, WSTRB=4'hF.
- ROUTING: latch address/length/index of selected slot -> PARAM_CHECK. Non-one-hot router -> ERROR, type 1.
- PARAM_CHECK: address[1:0]!=0 or length==0 -> ERROR, type 2; else clear offset, counters -> CALC.
- CALC: remaining = length - offset; room = 9'd256 - (address[9:2] + offset[7:0]) mod 256, giving 1..256 (9-bit, 256 legal); burst_len = min(room, remaining) -> AW.
- AW: AWADDR = address + offset*4, AWLEN = burst_len-1, AWVALID=1 until AWREADY sampled high; then AWVALID=0, beat=0 -> WDATA.
- WDATA: WDATA = selected lane, WVALID = selected valid, WLAST = (beat==burst_len-1). Handshake when WVALID&WREADY: data_next[idx] pulses that cycle (combinational WREADY&valid&state); other data_next bits 0. On the last handshake -> BRESP, else beat+1. No AXI lane driven from unselected sources.
- BRESP: BREADY=1; on BVALID: BRESP!=0 -> ERROR type 6; else offset += burst_len; offset>=length -> DONE, else -> CALC.
- Timeout counter: increments each cycle in AW, WDATA, BRESP without handshake progress; clears on any handshake and on state change. Bit TIMEOUT_BIT set -> ERROR, type 3/4/5 by state; counter checked before the FSM step.
- WDATA stall from empty source also counts toward W timeout.
- DONE and ERROR are sticky until reset; all VALID/READY outputs 0 in both; error_type held.
- Reset asserted mid-burst: outputs return to reset values next edge; no completion of the AXI burst is attempted.
- Only one burst outstanding; no AW issued before previous B accepted.

Test Plan:
- router=1, addr 0x1000, len 4, data 0xA0..0xA3, WREADY always 1 -> one AW (0x1000, AWLEN 3), 4 beats with WLAST on 0xA3, BRESP 0 -> done; data_next[0] pulses 4 times.
- router=4, addr 0x3F8, len 6 -> AW 0x3F8 AWLEN 1, then AW 0x400 AWLEN 3; done after second B.
- router=8, addr 0, len 300, WREADY toggling 50% -> bursts of 256 and 44 beats, no word lost or duplicated; done.
- router=4'b0011 -> error, type 1; addr 0x1002 -> type 2; len 0 -> type 2; no AWVALID in any case.
- BRESP=2'b10 on first burst of len 300 -> error type 6, no second AW.
- TIMEOUT_BIT=6, AWREADY held 0 -> error type 3 after 64 cycles; separately source valid held 0 -> type 4; BVALID held 0 -> type 5.
